// File: rtl/updown_level_fsm_pkg.sv
// Shared step-decision type and wrap/saturate mode constants for the up/down
// level selector.
package level_fsm_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_LOAD
  } step_e;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

// File: rtl/updown_level_fsm_if.sv
// Button, load and status bundle of the up/down level selector; the selector
// sits on the slave side, whoever drives the buttons and load on the master side.
interface updown_level_fsm_if #(
  parameter int WIDTH = 2
);
  import level_fsm_pkg::*;

  logic             d;
  logic             r;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] level;
  logic             at_min;
  logic             at_max;
  logic             changed;
  logic             blocked;
  logic             wrapped;

  modport master (
    output d, r, load, load_val,
    input  level, at_min, at_max, changed, blocked, wrapped
  );

  modport slave (
    input  d, r, load, load_val,
    output level, at_min, at_max, changed, blocked, wrapped
  );

endinterface

// File: rtl/updown_level_fsm_button_edge.sv
// One push-button path: synchroniser, optional debounce filter and a
// rising-edge detector, so each accepted press gives a single-cycle pulse.
module button_edge
  import level_fsm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_out;
  logic filtered;
  logic filtered_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = btn;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= btn;
          for (int j = 1; j < SYNC_STAGES; j++) begin
            sync_q[j] <= sync_q[j-1];
          end
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end

    if (DEBOUNCE == 0) begin : g_nofilt
      assign filtered = sync_out;
    end else begin : g_filt
      localparam int            CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
      logic [CW-1:0] cnt;
      logic          filt_q;

      // Any sample agreeing with the accepted value restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync_out != filt_q) begin
          if (cnt == LAST) begin
            filt_q <= sync_out;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      assign filtered = filt_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      filtered_q <= 1'b0;
    end else begin
      filtered_q <= filtered;
    end
  end

  assign pulse = filtered & ~filtered_q;

endmodule

// File: rtl/updown_level_fsm.sv
// Up/down level selector: two debounced buttons step a level register that
// saturates or wraps at 0..MAX_LEVEL, with parallel load and event pulses.
module updown_level_fsm
  import level_fsm_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int MAX_LEVEL   = 3,
  parameter int WRAP        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input logic               clk,
  input logic               rst,
  updown_level_fsm_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_LEVEL);

  logic             up_pulse;
  logic             down_pulse;
  step_e            step;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_next;
  logic             blocked_next;
  logic             wrapped_next;
  logic             changed_q;
  logic             blocked_q;
  logic             wrapped_q;

  button_edge #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.d),
    .pulse (up_pulse)
  );

  button_edge #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.r),
    .pulse (down_pulse)
  );

  // Load overrides buttons; simultaneous up and down cancel to a silent hold.
  always_comb begin
    step = STEP_HOLD;
    if (bus.load) begin
      step = STEP_LOAD;
    end else if (up_pulse && !down_pulse) begin
      step = STEP_UP;
    end else if (down_pulse && !up_pulse) begin
      step = STEP_DOWN;
    end
  end

  always_comb begin
    level_next   = level_q;
    blocked_next = 1'b0;
    wrapped_next = 1'b0;
    case (step)
      STEP_LOAD: level_next = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
      STEP_UP: begin
        if (level_q != MAX_W) begin
          level_next = level_q + 1'b1;
        end else if (WRAP == MODE_WRAP) begin
          level_next   = '0;
          wrapped_next = 1'b1;
        end else begin
          blocked_next = 1'b1;
        end
      end
      STEP_DOWN: begin
        if (level_q != '0) begin
          level_next = level_q - 1'b1;
        end else if (WRAP == MODE_WRAP) begin
          level_next   = MAX_W;
          wrapped_next = 1'b1;
        end else begin
          blocked_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      changed_q <= 1'b0;
      blocked_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      level_q   <= level_next;
      changed_q <= (level_next != level_q);
      blocked_q <= blocked_next;
      wrapped_q <= wrapped_next;
    end
  end

  assign bus.level   = level_q;
  assign bus.at_min  = (level_q == '0);
  assign bus.at_max  = (level_q == MAX_W);
  assign bus.changed = changed_q;
  assign bus.blocked = blocked_q;
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_updown_level_fsm.sv
// Three differently configured level selectors share one stimulus stream and
// are compared every cycle against a timeline model of presses and level rules.
module tb_updown_level_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_in = 1'b0;
  logic       r_in = 1'b0;
  logic       ld_in = 1'b0;
  logic [2:0] lv_in = 3'd0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  updown_level_fsm_if #(.WIDTH(2)) if_a ();
  updown_level_fsm_if #(.WIDTH(3)) if_b ();
  updown_level_fsm_if #(.WIDTH(2)) if_c ();

  assign if_a.d = d_in;
  assign if_a.r = r_in;
  assign if_a.load = ld_in;
  assign if_a.load_val = lv_in[1:0];
  assign if_b.d = d_in;
  assign if_b.r = r_in;
  assign if_b.load = ld_in;
  assign if_b.load_val = lv_in;
  assign if_c.d = d_in;
  assign if_c.r = r_in;
  assign if_c.load = ld_in;
  assign if_c.load_val = lv_in[1:0];

  // a: defaults, full-range saturate; b: wrap with debounce; c: same-edge response
  updown_level_fsm #(.WIDTH(2), .MAX_LEVEL(3), .WRAP(0), .SYNC_STAGES(2), .DEBOUNCE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  updown_level_fsm #(.WIDTH(3), .MAX_LEVEL(5), .WRAP(1), .SYNC_STAGES(2), .DEBOUNCE(4))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  updown_level_fsm #(.WIDTH(2), .MAX_LEVEL(2), .WRAP(0), .SYNC_STAGES(0), .DEBOUNCE(0))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int P_MAX  [3] = '{3, 5, 2};
  int P_WRAP [3] = '{0, 1, 0};
  int P_SYNC [3] = '{2, 2, 0};
  int P_DEB  [3] = '{0, 4, 0};
  int P_MASK [3] = '{3, 7, 3};

  string NAMES [6] = '{"level", "changed", "blocked", "wrapped", "at_min", "at_max"};

  bit hd[$];
  bit hr[$];
  bit hrst[$];

  int filt [3][2];
  int runs [3][2];
  int prev [3][2];
  int lvl  [3];
  int ech  [3];
  int ebl  [3];
  int ewr  [3];

  // Synchronised view of a button at edge m: the raw sample SYNC edges back,
  // or 0 if a reset edge fell inside that window.
  function automatic bit syncView(int i, int b, int m);
    int s = P_SYNC[i];
    if (s == 0) return (b == 0) ? hd[m] : hr[m];
    if (m - s < 0) return 1'b0;
    for (int e = m - s; e < m; e++) begin
      if (hrst[e]) return 1'b0;
    end
    return (b == 0) ? hd[m - s] : hr[m - s];
  endfunction

  task automatic modelEdge(input bit dv, input bit rv, input bit ldv, input int lvv, input bit rsv);
    int m;
    int pulses [2];
    int s, now, nl, old;
    hd.push_back(dv);
    hr.push_back(rv);
    hrst.push_back(rsv);
    m = hd.size() - 1;
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 2; b++) begin
        s = int'(syncView(i, b, m));
        now = (P_DEB[i] == 0) ? s : filt[i][b];
        pulses[b] = (now == 1 && prev[i][b] == 0) ? 1 : 0;
        if (rsv) begin
          filt[i][b] = 0;
          runs[i][b] = 0;
          prev[i][b] = 0;
        end else begin
          prev[i][b] = now;
          if (P_DEB[i] > 0) begin
            if (s != filt[i][b]) begin
              runs[i][b]++;
              if (runs[i][b] == P_DEB[i]) begin
                filt[i][b] = s;
                runs[i][b] = 0;
              end
            end else begin
              runs[i][b] = 0;
            end
          end
        end
      end
      if (rsv) begin
        lvl[i] = 0; ech[i] = 0; ebl[i] = 0; ewr[i] = 0;
      end else begin
        old = lvl[i];
        nl = old;
        ebl[i] = 0;
        ewr[i] = 0;
        if (ldv) begin
          nl = lvv & P_MASK[i];
          if (nl > P_MAX[i]) nl = P_MAX[i];
        end else if (pulses[0] == 1 && pulses[1] == 1) begin
          nl = old;
        end else if (pulses[0] == 1) begin
          if (old < P_MAX[i]) nl = old + 1;
          else if (P_WRAP[i] == 1) begin nl = 0; ewr[i] = 1; end
          else ebl[i] = 1;
        end else if (pulses[1] == 1) begin
          if (old > 0) nl = old - 1;
          else if (P_WRAP[i] == 1) begin nl = P_MAX[i]; ewr[i] = 1; end
          else ebl[i] = 1;
        end
        ech[i] = (nl != old) ? 1 : 0;
        lvl[i] = nl;
      end
    end
  endtask

  task automatic checkOutput();
    int obs [3][6];
    int exp [3][6];
    obs[0] = '{int'(if_a.level), int'(if_a.changed), int'(if_a.blocked),
               int'(if_a.wrapped), int'(if_a.at_min), int'(if_a.at_max)};
    obs[1] = '{int'(if_b.level), int'(if_b.changed), int'(if_b.blocked),
               int'(if_b.wrapped), int'(if_b.at_min), int'(if_b.at_max)};
    obs[2] = '{int'(if_c.level), int'(if_c.changed), int'(if_c.blocked),
               int'(if_c.wrapped), int'(if_c.at_min), int'(if_c.at_max)};
    for (int i = 0; i < 3; i++) begin
      exp[i] = '{lvl[i], ech[i], ebl[i], ewr[i],
                 (lvl[i] == 0) ? 1 : 0, (lvl[i] == P_MAX[i]) ? 1 : 0};
      for (int k = 0; k < 6; k++) begin
        vectors++;
        assert (obs[i][k] === exp[i][k]) else begin
          miscompares++;
          $error("[TB] FAIL %s dut%0d at %0t: observed %0d expected %0d",
                 NAMES[k], i, $time, obs[i][k], exp[i][k]);
        end
      end
    end
  endtask

  task automatic checkConst(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit dv, input bit rv, input bit ldv,
                               input int lvv, input bit rsv, input int n);
    repeat (n) begin
      d_in  = dv;
      r_in  = rv;
      ld_in = ldv;
      lv_in = 3'(lvv);
      rst   = rsv;
      @(posedge clk);
      modelEdge(dv, rv, ldv, lvv, rsv);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      lvl[i] = 0; ech[i] = 0; ebl[i] = 0; ewr[i] = 0;
      for (int b = 0; b < 2; b++) begin
        filt[i][b] = 0; runs[i][b] = 0; prev[i][b] = 0;
      end
    end

    $display("[TB] reset with d held, then release");
    applyStimulus(1, 0, 0, 0, 1, 3);
    checkConst("reset_level_a", int'(if_a.level), 0);
    checkConst("reset_at_min_b", int'(if_b.at_min), 1);
    applyStimulus(1, 0, 0, 0, 0, 12);
    checkConst("held_press_a", int'(if_a.level), 1);
    checkConst("held_press_b", int'(if_b.level), 1);
    checkConst("held_press_c", int'(if_c.level), 1);
    applyStimulus(0, 0, 0, 0, 0, 12);

    $display("[TB] three more presses up to the limits");
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1, 0, 0, 0, 0, 10);
      applyStimulus(0, 0, 0, 0, 0, 10);
    end
    checkConst("sat_level_a", int'(if_a.level), 3);
    checkConst("sat_at_max_a", int'(if_a.at_max), 1);
    checkConst("climb_level_b", int'(if_b.level), 4);

    $display("[TB] bounce then short glitch");
    applyStimulus(1, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 6);
    applyStimulus(0, 0, 0, 0, 0, 10);
    applyStimulus(1, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkConst("debounce_level_b", int'(if_b.level), 5);

    $display("[TB] wrap up and down");
    applyStimulus(1, 0, 0, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkConst("wrap_up_b", int'(if_b.level), 0);
    applyStimulus(0, 1, 0, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkConst("wrap_down_b", int'(if_b.level), 5);

    $display("[TB] simultaneous up and down");
    applyStimulus(1, 1, 0, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkConst("both_level_a", int'(if_a.level), 2);

    $display("[TB] clamped load with coincident press, then reload");
    applyStimulus(1, 0, 1, 3, 0, 1);
    checkConst("load_clamp_c", int'(if_c.level), 2);
    applyStimulus(1, 0, 0, 0, 0, 9);
    applyStimulus(0, 0, 0, 0, 0, 10);
    checkConst("load_then_step_b", int'(if_b.level), 4);
    applyStimulus(0, 0, 1, 2, 0, 1);
    checkConst("reload_changed_c", int'(if_c.changed), 0);
    applyStimulus(0, 0, 0, 0, 0, 3);

    $display("[TB] random phase");
    for (int s = 0; s < 150; s++) begin
      bit dv, rv;
      dv = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) applyStimulus(dv, rv, 1, int'($urandom_range(0, 7)), 0, 1);
      if ($urandom_range(0, 40) == 0) applyStimulus(dv, rv, 0, 0, 1, 2);
      applyStimulus(dv, rv, 0, int'($urandom_range(0, 7)), 0, int'($urandom_range(1, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
